// File: rtl/msk_frame_sync.sv
// Bit-stream frame synchronizer: Hamming-tolerant sync search, byte de-framing, flywheel lock.
// Optional inverted-polarity sync acceptance is enabled by defining MSK_FSYNC_INV_EN.
module msk_frame_sync #(
  parameter int unsigned        SYNC_W        = 32,
  parameter logic [SYNC_W-1:0]  SYNC_WORD     = SYNC_W'(32'h1ACFFC1D),
  parameter int unsigned        MAX_ERR       = 2,
  parameter int unsigned        PAYLOAD_BYTES = 32,
  parameter int unsigned        LOCK_MISS     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_i,
  input  logic        data_val_i,
  output logic [7:0]  byte_o,
  output logic        byte_val_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        sync_det_o,
  output logic        frame_err_o,
  output logic        locked_o,
  output logic        inverted_o,
  output logic [15:0] frame_cnt_o
);

  localparam int unsigned DIST_W = $clog2(SYNC_W + 1);
  localparam int unsigned CHK_W  = $clog2(SYNC_W);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  function automatic logic [DIST_W-1:0] popcount(input logic [SYNC_W-1:0] v);
    logic [DIST_W-1:0] c;
    c = '0;
    for (int i = 0; i < SYNC_W; i++) c = c + DIST_W'(v[i]);
    return c;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [SYNC_W-1:0]  r_sr, w_sr_nxt;
  logic [2:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]         r_byte_cnt, w_byte_cnt_nxt;
  logic [CHK_W-1:0]   r_chk_cnt, w_chk_cnt_nxt;
  logic [3:0]         r_miss_cnt, w_miss_cnt_nxt;
  logic [6:0]         r_byte_sh, w_byte_sh_nxt;
  logic [7:0]         r_byte, w_byte_nxt;
  logic               r_byte_val, w_byte_val_nxt;
  logic               r_sof, w_sof_nxt;
  logic               r_eof, w_eof_nxt;
  logic               r_sync_det, w_sync_det_nxt;
  logic               r_frame_err, w_frame_err_nxt;
  logic               r_locked, w_locked_nxt;
  logic [15:0]        r_frame_cnt, w_frame_cnt_nxt;

  logic [SYNC_W-1:0]  w_pattern;
  logic [DIST_W-1:0]  w_dist;
  logic               w_match_n;
  logic               w_match_i;
  logic               w_inv;
  logic               w_bit;
  logic               w_search_hit;
  logic               w_chk_match;

  // Distance of the window that includes the bit currently on data_i
  assign w_pattern    = {r_sr[SYNC_W-2:0], data_i};
  assign w_dist       = popcount(w_pattern ^ SYNC_WORD);
  assign w_match_n    = (w_dist <= DIST_W'(MAX_ERR));
  assign w_bit        = data_i ^ w_inv;
  assign w_search_hit = (r_state == ST_SEARCH) && data_val_i && (w_match_n || w_match_i);
  assign w_chk_match  = w_inv ? w_match_i : w_match_n;

`ifdef MSK_FSYNC_INV_EN
  logic r_inverted;

  // Inverted distance is the complement count; normal polarity wins a tie
  assign w_match_i = ((DIST_W'(SYNC_W) - w_dist) <= DIST_W'(MAX_ERR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_inverted <= 1'b0;
    else if (w_search_hit) r_inverted <= ~w_match_n;
  end

  assign w_inv = r_inverted;
`else
  assign w_match_i = 1'b0;
  assign w_inv     = 1'b0;
`endif

  assign inverted_o = w_inv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_SEARCH;
    else     r_state <= w_state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_sr_nxt        = r_sr;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_chk_cnt_nxt   = r_chk_cnt;
    w_miss_cnt_nxt  = r_miss_cnt;
    w_byte_sh_nxt   = r_byte_sh;
    w_byte_nxt      = r_byte;
    w_byte_val_nxt  = 1'b0;
    w_sof_nxt       = 1'b0;
    w_eof_nxt       = 1'b0;
    w_sync_det_nxt  = 1'b0;
    w_frame_err_nxt = r_frame_err;
    w_locked_nxt    = r_locked;
    w_frame_cnt_nxt = r_frame_cnt;

    if (data_val_i) w_sr_nxt = w_pattern;

    case (r_state)
      ST_SEARCH: begin
        if (w_search_hit) begin
          w_state_nxt     = ST_PAYLOAD;
          w_sync_det_nxt  = 1'b1;
          w_locked_nxt    = 1'b1;
          w_frame_err_nxt = 1'b0;
          w_miss_cnt_nxt  = '0;
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          w_bit_cnt_nxt   = '0;
          w_byte_cnt_nxt  = '0;
        end
      end

      ST_PAYLOAD: begin
        if (data_val_i) begin
          w_byte_sh_nxt = {r_byte_sh[5:0], w_bit};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_byte_nxt     = {r_byte_sh, w_bit};
            w_byte_val_nxt = 1'b1;
            w_sof_nxt      = (r_byte_cnt == 8'd0);
            w_eof_nxt      = (r_byte_cnt == 8'(PAYLOAD_BYTES - 1));
            if (r_byte_cnt == 8'(PAYLOAD_BYTES - 1)) begin
              w_state_nxt    = ST_CHECK;
              w_byte_cnt_nxt = '0;
              w_chk_cnt_nxt  = '0;
            end else begin
              w_byte_cnt_nxt = r_byte_cnt + 8'd1;
            end
          end
        end
      end

      ST_CHECK: begin
        if (data_val_i) begin
          w_chk_cnt_nxt = r_chk_cnt + CHK_W'(1);
          if (r_chk_cnt == CHK_W'(SYNC_W - 1)) begin
            w_bit_cnt_nxt  = '0;
            w_byte_cnt_nxt = '0;
            if (w_chk_match) begin
              w_state_nxt     = ST_PAYLOAD;
              w_sync_det_nxt  = 1'b1;
              w_miss_cnt_nxt  = '0;
              w_frame_err_nxt = 1'b0;
              w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            end else if ((r_miss_cnt + 4'd1) == 4'(LOCK_MISS)) begin
              w_state_nxt    = ST_SEARCH;
              w_locked_nxt   = 1'b0;
              w_miss_cnt_nxt = '0;
            end else begin
              w_state_nxt     = ST_PAYLOAD;
              w_miss_cnt_nxt  = r_miss_cnt + 4'd1;
              w_frame_err_nxt = 1'b1;
            end
          end
        end
      end

      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr        <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_chk_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_byte_sh   <= '0;
      r_byte      <= '0;
      r_byte_val  <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_sync_det  <= 1'b0;
      r_frame_err <= 1'b0;
      r_locked    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_chk_cnt   <= w_chk_cnt_nxt;
      r_miss_cnt  <= w_miss_cnt_nxt;
      r_byte_sh   <= w_byte_sh_nxt;
      r_byte      <= w_byte_nxt;
      r_byte_val  <= w_byte_val_nxt;
      r_sof       <= w_sof_nxt;
      r_eof       <= w_eof_nxt;
      r_sync_det  <= w_sync_det_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_locked    <= w_locked_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  assign byte_o      = r_byte;
  assign byte_val_o  = r_byte_val;
  assign sof_o       = r_sof;
  assign eof_o       = r_eof;
  assign sync_det_o  = r_sync_det;
  assign frame_err_o = r_frame_err;
  assign locked_o    = r_locked;
  assign frame_cnt_o = r_frame_cnt;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed self-checking bench for msk_frame_sync (default parameters).
module tb_msk_frame_sync;

  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_i;
  logic        data_val_i;
  logic [7:0]  byte_o;
  logic        byte_val_o;
  logic        sof_o;
  logic        eof_o;
  logic        sync_det_o;
  logic        frame_err_o;
  logic        locked_o;
  logic        inverted_o;
  logic [15:0] frame_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q_byte[$];
  bit         q_sof[$];
  bit         q_eof[$];
  bit         q_ferr[$];
  int         sync_cnt;

  msk_frame_sync dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .data_val_i  (data_val_i),
    .byte_o      (byte_o),
    .byte_val_o  (byte_val_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .sync_det_o  (sync_det_o),
    .frame_err_o (frame_err_o),
    .locked_o    (locked_o),
    .inverted_o  (inverted_o),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Output capture, sampled mid-cycle
  always @(negedge clk) begin
    if (byte_val_o) begin
      q_byte.push_back(byte_o);
      q_sof.push_back(sof_o);
      q_eof.push_back(eof_o);
      q_ferr.push_back(frame_err_o);
    end
    if (sync_det_o) sync_cnt++;
  end

  task automatic send_bit(input logic b);
    data_i     = b;
    data_val_i = 1'b1;
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    q_byte.delete();
    q_sof.delete();
    q_eof.delete();
    q_ferr.delete();
    sync_cnt = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    clear_mon();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({byte_o, byte_val_o, sof_o, eof_o, sync_det_o, frame_err_o, locked_o, inverted_o, frame_cnt_o} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got byte=%h val=%b sof=%b eof=%b det=%b ferr=%b lock=%b inv=%b cnt=%0d expected all 0",
               byte_o, byte_val_o, sof_o, eof_o, sync_det_o, frame_err_o, locked_o, inverted_o, frame_cnt_o);
    end
  endtask

  task automatic test_basic_frame();
    int nsof;
    int neof;
    do_reset();
    for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
    send_word(SYNC);
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    idle(2);
    n_tests++;
    if (sync_cnt !== 1) begin
      n_fail++;
      $display("FAIL basic_sync_det got %0d expected 1", sync_cnt);
    end
    n_tests++;
    if (q_byte.size() !== 32) begin
      n_fail++;
      $display("FAIL basic_byte_count got %0d expected 32", q_byte.size());
    end else begin
      nsof = 0;
      neof = 0;
      for (int i = 0; i < 32; i++) begin
        n_tests++;
        if (q_byte[i] !== 8'(i)) begin
          n_fail++;
          $display("FAIL basic_byte[%0d] got %h expected %h", i, q_byte[i], 8'(i));
        end
        nsof += int'(q_sof[i]);
        neof += int'(q_eof[i]);
      end
      n_tests++;
      if (q_sof[0] !== 1'b1 || nsof !== 1) begin
        n_fail++;
        $display("FAIL basic_sof got first=%b total=%0d expected first=1 total=1", q_sof[0], nsof);
      end
      n_tests++;
      if (q_eof[31] !== 1'b1 || neof !== 1) begin
        n_fail++;
        $display("FAIL basic_eof got last=%b total=%0d expected last=1 total=1", q_eof[31], neof);
      end
    end
    n_tests++;
    if (frame_cnt_o !== 16'd1 || locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_cnt_lock got cnt=%0d lock=%b expected cnt=1 lock=1", frame_cnt_o, locked_o);
    end
  endtask

  task automatic test_sync_errors();
    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    send_word(SYNC ^ 32'h0000_0011);
    idle(2);
    n_tests++;
    if (sync_cnt !== 1 || locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err2_accept got det=%0d lock=%b expected det=1 lock=1", sync_cnt, locked_o);
    end
    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    send_word(SYNC ^ 32'h0100_0011);
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    idle(2);
    n_tests++;
    if (sync_cnt !== 0 || locked_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err3_reject got det=%0d lock=%b expected det=0 lock=0", sync_cnt, locked_o);
    end
  endtask

  task automatic test_flywheel();
    logic [31:0] sw;
    logic [7:0]  exp_b;
    bit          exp_e;
    int          fr;
    do_reset();
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    for (int f = 1; f <= 7; f++) begin
      sw = (f >= 4 && f <= 6) ? 32'h0 : SYNC;
      send_word(sw);
      if (f == 4) begin
        idle(1);
        n_tests++;
        if (locked_o !== 1'b1 || frame_err_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fly_miss1 got lock=%b ferr=%b expected lock=1 ferr=1", locked_o, frame_err_o);
        end
      end
      if (f == 6) begin
        idle(1);
        n_tests++;
        if (locked_o !== 1'b0 || frame_err_o !== 1'b1) begin
          n_fail++;
          $display("FAIL fly_unlock got lock=%b ferr=%b expected lock=0 ferr=1", locked_o, frame_err_o);
        end
      end
      for (int i = 0; i < 32; i++) send_byte((f == 6) ? 8'h00 : 8'(f));
    end
    idle(2);
    n_tests++;
    if (sync_cnt !== 4 || frame_cnt_o !== 16'd4) begin
      n_fail++;
      $display("FAIL fly_sync_count got det=%0d cnt=%0d expected 4 and 4", sync_cnt, frame_cnt_o);
    end
    n_tests++;
    if (q_byte.size() !== 192) begin
      n_fail++;
      $display("FAIL fly_byte_count got %0d expected 192", q_byte.size());
    end else begin
      for (int k = 0; k < 192; k++) begin
        fr    = k / 32;
        exp_b = (fr < 5) ? 8'(fr + 1) : 8'd7;
        exp_e = (fr == 3 || fr == 4);
        n_tests++;
        if (q_byte[k] !== exp_b || q_ferr[k] !== exp_e) begin
          n_fail++;
          $display("FAIL fly_byte[%0d] got %h ferr=%b expected %h ferr=%b", k, q_byte[k], q_ferr[k], exp_b, exp_e);
        end
      end
    end
    n_tests++;
    if (locked_o !== 1'b1 || frame_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fly_relock got lock=%b ferr=%b expected lock=1 ferr=0", locked_o, frame_err_o);
    end
  endtask

  task automatic test_inverted();
    do_reset();
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    send_word(~SYNC);
    for (int i = 0; i < 32; i++) send_byte(8'h5A);
    idle(2);
`ifdef MSK_FSYNC_INV_EN
    n_tests++;
    if (sync_cnt !== 1 || locked_o !== 1'b1 || inverted_o !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_lock got det=%0d lock=%b inv=%b expected 1 1 1", sync_cnt, locked_o, inverted_o);
    end
    n_tests++;
    if (q_byte.size() !== 32 || q_byte[0] !== 8'hA5 || q_byte[31] !== 8'hA5) begin
      n_fail++;
      $display("FAIL inv_payload got n=%0d first=%h expected n=32 bytes A5", q_byte.size(), (q_byte.size() > 0) ? q_byte[0] : 8'h00);
    end
`else
    n_tests++;
    if (sync_cnt !== 0 || locked_o !== 1'b0 || inverted_o !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_nolock got det=%0d lock=%b inv=%b expected 0 0 0", sync_cnt, locked_o, inverted_o);
    end
    n_tests++;
    if (q_byte.size() !== 0) begin
      n_fail++;
      $display("FAIL inv_nobytes got %0d expected 0", q_byte.size());
    end
`endif
  endtask

  task automatic test_sync_in_payload();
    logic [7:0] pl [32];
    for (int i = 0; i < 32; i++) pl[i] = 8'(i + 8'h80);
    pl[4] = 8'h1A;
    pl[5] = 8'hCF;
    pl[6] = 8'hFC;
    pl[7] = 8'h1D;
    do_reset();
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    send_word(SYNC);
    for (int i = 0; i < 32; i++) send_byte(pl[i]);
    idle(2);
    n_tests++;
    if (sync_cnt !== 1 || frame_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL embed_sync got det=%0d cnt=%0d expected 1 and 1", sync_cnt, frame_cnt_o);
    end
    n_tests++;
    if (q_byte.size() !== 32) begin
      n_fail++;
      $display("FAIL embed_count got %0d expected 32", q_byte.size());
    end else begin
      for (int i = 3; i < 9; i++) begin
        n_tests++;
        if (q_byte[i] !== pl[i]) begin
          n_fail++;
          $display("FAIL embed_byte[%0d] got %h expected %h", i, q_byte[i], pl[i]);
        end
      end
      n_tests++;
      if (q_eof[31] !== 1'b1) begin
        n_fail++;
        $display("FAIL embed_eof got %b expected 1", q_eof[31]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    send_word(SYNC);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    n_tests++;
    if (q_byte.size() !== 10 || frame_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_before got n=%0d cnt=%0d expected 10 and 1", q_byte.size(), frame_cnt_o);
    end
    rst        = 1'b1;
    data_i     = 1'b1;
    data_val_i = 1'b1;
    #1;
    n_tests++;
    if ({byte_o, byte_val_o, sof_o, eof_o, sync_det_o, frame_err_o, locked_o, inverted_o, frame_cnt_o} !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_async_rst got byte=%h lock=%b cnt=%0d expected all 0", byte_o, locked_o, frame_cnt_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    send_word(SYNC);
    for (int i = 0; i < 32; i++) send_byte(8'(8'h40 + i));
    idle(2);
    n_tests++;
    if (sync_cnt !== 1 || frame_cnt_o !== 16'd1 || locked_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_relock got det=%0d cnt=%0d lock=%b expected 1 1 1", sync_cnt, frame_cnt_o, locked_o);
    end
    n_tests++;
    if (q_byte.size() !== 32) begin
      n_fail++;
      $display("FAIL mid_count got %0d expected 32", q_byte.size());
    end else begin
      n_tests++;
      if (q_byte[0] !== 8'h40 || q_sof[0] !== 1'b1 || q_byte[31] !== 8'h5F || q_eof[31] !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_bytes got first=%h sof=%b last=%h eof=%b expected 40 1 5F 1",
                 q_byte[0], q_sof[0], q_byte[31], q_eof[31]);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    sync_cnt   = 0;
    void'($urandom(32'd1234));
    test_reset();
    test_basic_frame();
    test_sync_errors();
    test_flywheel();
    test_inverted();
    test_sync_in_payload();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
